// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM-stage port: a word RAM behind a
// fixed-latency access FSM that holds the pipeline while a request is in flight.
module dmem_resp #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_m,
    input  logic        memwrite_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] writedata_m,
    output logic [31:0] readdata_m,
    output logic        stall_m,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0]   ram [DEPTH];
    logic [AW-1:0] idx;
    logic          req;
    logic          aligned;
    logic          in_idle;
    logic          unused_bits;

    // Upper address bits alias; memread_m only matters through req.
    assign idx         = aluout_m[AW+1:2];
    assign req         = memread_m | memwrite_m;
    assign aligned     = (aluout_m[1:0] == 2'b00);
    assign unused_bits = ^{aluout_m[31:AW+2], memread_m};

    always_ff @(posedge clk) begin
        if (reset)
            misalign_err <= 1'b0;
        else if (in_idle && req && !aligned)
            misalign_err <= 1'b1;
    end

    generate
        if (LATENCY == 0) begin : g_zws
            assign in_idle    = 1'b1;
            assign stall_m    = 1'b0;
            assign readdata_m = ram[idx];

            always_ff @(posedge clk) begin
                if (!reset && memwrite_m && aligned)
                    ram[idx] <= writedata_m;
            end
        end else begin : g_fsm
            typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

            state_t        state, state_n;
            logic [CW-1:0] cnt, cnt_n;
            logic          lat_wr;
            logic [AW-1:0] lat_idx;
            logic [31:0]   lat_data;
            logic [31:0]   rdata;
            logic          load_rd;
            logic [AW-1:0] rd_idx;
            logic          start;

            assign start   = (state == IDLE) && req && aligned;
            assign in_idle = (state == IDLE);

            always_comb begin
                state_n = state;
                cnt_n   = cnt;
                load_rd = 1'b0;
                rd_idx  = lat_idx;
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (LATENCY == 1) begin
                                // Single-cycle access: latch is not yet loaded.
                                state_n = DONE;
                                load_rd = !memwrite_m;
                                rd_idx  = idx;
                            end else begin
                                state_n = WAIT;
                                cnt_n   = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
                            end
                        end
                    end
                    WAIT: begin
                        if (cnt == '0) begin
                            state_n = DONE;
                            load_rd = !lat_wr;
                        end else begin
                            cnt_n = cnt - 1'b1;
                        end
                    end
                    DONE:    state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    rdata  <= '0;
                    lat_wr <= 1'b0;
                end else begin
                    state <= state_n;
                    cnt   <= cnt_n;
                    if (load_rd)
                        rdata <= ram[rd_idx];
                    if (start)
                        lat_wr <= memwrite_m;
                end
            end

            always_ff @(posedge clk) begin
                if (start) begin
                    lat_idx  <= idx;
                    lat_data <= writedata_m;
                end
            end

            // Store commits at the DONE edge; reset discards it.
            always_ff @(posedge clk) begin
                if (!reset && state == DONE && lat_wr)
                    ram[lat_idx] <= lat_data;
            end

            assign stall_m    = !reset && (start || state == WAIT);
            assign readdata_m = rdata;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: per-cycle model comparison on a LATENCY=2 instance,
// plus directed checks on LATENCY=1 and LATENCY=0 builds.
module tb_dmem_resp;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread_m, memwrite_m;
    logic [31:0] aluout_m, writedata_m;
    logic [31:0] readdata_m;
    logic        stall_m, misalign_err;

    logic        s_rd, s_wr;
    logic [31:0] s_addr, s_data;
    logic [31:0] l1_rd, l0_rd;
    logic        l1_stall, l0_stall, l1_err, l0_err;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] mem_m [DEPTH];
    int          stall_seen = 0;
    int          l1_hits = 0;
    int          l0_hits = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .memread_m(memread_m), .memwrite_m(memwrite_m),
        .aluout_m(aluout_m), .writedata_m(writedata_m),
        .readdata_m(readdata_m), .stall_m(stall_m),
        .misalign_err(misalign_err)
    );

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .memread_m(s_rd), .memwrite_m(s_wr),
        .aluout_m(s_addr), .writedata_m(s_data),
        .readdata_m(l1_rd), .stall_m(l1_stall),
        .misalign_err(l1_err)
    );

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .memread_m(s_rd), .memwrite_m(s_wr),
        .aluout_m(s_addr), .writedata_m(s_data),
        .readdata_m(l0_rd), .stall_m(l0_stall),
        .misalign_err(l0_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'b0, stall_m}, {31'b0, exp_stall});
            chk("readdata", readdata_m, exp_rd);
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_err});
            if (stall_m) stall_seen++;
        end
        if (l1_stall) l1_hits++;
        if (l0_stall) l0_hits++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: a request in cycle t stalls t..t+LAT-1, DONE at t+LAT,
    // store lands in memory at the DONE edge.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'(a[31:2] % DEPTH);
        memread_m   = rd;
        memwrite_m  = wr;
        aluout_m    = a;
        writedata_m = d;
        if (a[1:0] != 2'b00) begin
            exp_stall = 1'b0;
            cyc();
            exp_err = 1'b1;
        end else begin
            exp_stall = 1'b1;
            for (int k = 1; k < LAT; k++) cyc();
            cyc();
            exp_stall = 1'b0;
            if (rd && !wr) exp_rd = mem_m[i];
            cyc();
            if (wr) mem_m[i] = d;
        end
        memread_m  = 1'b0;
        memwrite_m = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        memread_m = 1'b0; memwrite_m = 1'b0;
        aluout_m = '0; writedata_m = '0;
        s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_data = '0;
        exp_stall = 1'b0; exp_rd = '0; exp_err = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readdata", readdata_m, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_stall", {31'b0, stall_m}, 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        stall_seen = 0;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("store_stall_cycles", stall_seen, 2);
        stall_seen = 0;
        access(1'b1, 1'b0, 32'h10, 32'h0);
        chk("load_stall_cycles", stall_seen, 2);
        chk("load_10", readdata_m, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'h104, 32'h12345678);
        access(1'b1, 1'b0, 32'h004, 32'h0);
        chk("alias_load_004", readdata_m, 32'h12345678);

        access(1'b0, 1'b1, 32'h20, 32'h01020304);
        stall_seen = 0;
        access(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF);
        chk("misalign_no_stall", stall_seen, 0);
        cyc();
        chk("misalign_sticky", {31'b0, misalign_err}, 32'h1);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        chk("misalign_no_write", readdata_m, 32'h01020304);

        access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
        chk("both_keeps_rd", readdata_m, 32'h01020304);
        access(1'b1, 1'b0, 32'h30, 32'h0);
        chk("both_is_write", readdata_m, 32'hCAFEF00D);

        access(1'b0, 1'b1, 32'h08, 32'h11111111);
        memwrite_m  = 1'b1;
        aluout_m    = 32'h08;
        writedata_m = 32'hAAAA5555;
        exp_stall   = 1'b1;
        cyc();
        reset     = 1'b1;
        exp_stall = 1'b0;
        cyc();
        reset      = 1'b0;
        memwrite_m = 1'b0;
        exp_rd     = '0;
        exp_err    = 1'b0;
        cyc();
        chk("rst_clears_err", {31'b0, misalign_err}, 32'h0);
        access(1'b1, 1'b0, 32'h08, 32'h0);
        chk("rst_drops_write", readdata_m, 32'h11111111);

        s_wr = 1'b1; s_addr = 32'h0C; s_data = 32'h5A5A0001;
        @(negedge clk);
        chk("l1_store_stall", {31'b0, l1_stall}, 32'h1);
        chk("l0_store_stall", {31'b0, l0_stall}, 32'h0);
        cyc();
        @(negedge clk);
        chk("l1_store_done", {31'b0, l1_stall}, 32'h0);
        cyc();
        s_wr = 1'b0; s_rd = 1'b1;
        @(negedge clk);
        chk("l0_load_same_cycle", l0_rd, 32'h5A5A0001);
        chk("l1_load_stall", {31'b0, l1_stall}, 32'h1);
        cyc();
        @(negedge clk);
        chk("l1_load_done", {31'b0, l1_stall}, 32'h0);
        chk("l1_load_data", l1_rd, 32'h5A5A0001);
        cyc();
        s_rd = 1'b0;
        cyc();
        chk("l1_total_stalls", l1_hits, 2);
        chk("l0_never_stalls", l0_hits, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
